// File: rtl/io_led_switch_responder_pkg.sv
// Purpose: shared IO map constants and debounce state type for the LED/switch responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package io_map_pkg;

  localparam logic [31:0] LED_BASE = 32'hFFFF_FC60;
  localparam logic [31:0] SW_BASE  = 32'hFFFF_FC70;

  // Halfword offsets within each peripheral window
  localparam logic [31:0] OFF_LO = 32'd0;
  localparam logic [31:0] OFF_HI = 32'd2;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } deb_state_e;

endpackage

// File: rtl/io_led_switch_responder_if.sv
// Purpose: CPU-side memory-mapped IO bus (address, strobes, chip-selects, read data).
// Latency: n/a (wires only).
// Backpressure: none; strobes are single-cycle and always accepted.
interface io_led_switch_responder_if;

  logic [31:0] address;
  logic [31:0] write_data;
  logic        iowrite;
  logic        ioread;
  logic        LEDCtrl;
  logic        SwitchCtrl;
  logic [15:0] ioread_data;

  // CPU side drives the request, consumes read data
  modport master (
    output address, write_data, iowrite, ioread, LEDCtrl, SwitchCtrl,
    input  ioread_data
  );

  // Peripheral side consumes the request, returns read data
  modport slave (
    input  address, write_data, iowrite, ioread, LEDCtrl, SwitchCtrl,
    output ioread_data
  );

endinterface

// File: rtl/io_led_switch_responder_debounce.sv
// Purpose: 2-flop synchronizer plus whole-vector debouncer for raw board switches.
// Latency: a stable pin change appears on deb_o 2 + DEBOUNCE_CYCLES cycles later.
// Backpressure: none; free-running sampler.
module switch_debounce
  import io_map_pkg::*;
#(
  parameter int          W               = 24,
  parameter int          CNT_W           = 20,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] pins_i,
  output logic [W-1:0] deb_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [W-1:0]     s1_q;
  logic [W-1:0]     s2_q;
  logic [W-1:0]     cand_q;
  logic [W-1:0]     deb_q;
  logic [CNT_W-1:0] cnt_q;
  deb_state_e       state_q;

  // Synchronize raw pins, then accept a new vector only after it holds for the full window
  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      cand_q  <= '0;
      deb_q   <= '0;
      cnt_q   <= '0;
      state_q <= STABLE;
    end else begin
      s1_q <= pins_i;
      s2_q <= s1_q;
      case (state_q)
        STABLE: begin
          if (s2_q != deb_q) begin
            state_q <= COUNTING;
            cand_q  <= s2_q;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q <= '0;
          end
        end
        COUNTING: begin
          // Bounce back to the accepted value is checked first: the candidate
          // always differs from deb, so this case would otherwise look like a restart.
          if (s2_q == deb_q) begin
            state_q <= STABLE;
            cnt_q   <= '0;
          end else if (s2_q != cand_q) begin
            cand_q <= s2_q;
            cnt_q  <= CNT_ONE;
          end else if (cnt_q >= CNT_LAST) begin
            deb_q   <= cand_q;
            state_q <= STABLE;
            cnt_q   <= '0;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= STABLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/io_led_switch_responder.sv
// Purpose: IO responder decoding CPU writes into 24 LED registers and returning debounced switches.
// Latency: LED write visible 1 cycle after the edge; switch read data is combinational.
// Backpressure: none; every strobe is accepted, unmapped accesses set the sticky io_err.
module io_led_switch_responder
  import io_map_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int          CNT_W           = 20
) (
  input  logic                          clock,
  input  logic                          reset,
  io_led_switch_responder_if.slave      bus,
  input  logic [23:0]                   switch_pins,
  output logic [23:0]                   led_pins,
  output logic                          io_err
);

  localparam logic [31:0] LED_LO_A = LED_BASE + OFF_LO;
  localparam logic [31:0] LED_HI_A = LED_BASE + OFF_HI;
  localparam logic [31:0] SW_LO_A  = SW_BASE + OFF_LO;
  localparam logic [31:0] SW_HI_A  = SW_BASE + OFF_HI;

  logic [23:0] led_q;
  logic [23:0] led_d;
  logic        err_q;
  logic        err_d;
  logic [15:0] rdata;
  logic [23:0] deb;
  logic        wr_sel;
  logic        rd_sel;
  logic        unused_wdata;

  // Only the low halfword of store data reaches the LEDs
  assign unused_wdata = ^bus.write_data[31:16];

  switch_debounce #(
    .W              (24),
    .CNT_W          (CNT_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock (clock),
    .reset (reset),
    .pins_i(switch_pins),
    .deb_o (deb)
  );

  assign wr_sel = bus.iowrite & bus.LEDCtrl;
  assign rd_sel = bus.ioread & bus.SwitchCtrl;

  // Decode write and read paths independently; either path can raise the error flag
  always_comb begin
    led_d = led_q;
    err_d = err_q;
    rdata = 16'h0000;
    if (wr_sel) begin
      if (bus.address == LED_LO_A) begin
        led_d[15:0] = bus.write_data[15:0];
      end else if (bus.address == LED_HI_A) begin
        led_d[23:16] = bus.write_data[7:0];
      end else begin
        err_d = 1'b1;
      end
    end
    if (rd_sel) begin
      if (bus.address == SW_LO_A) begin
        rdata = deb[15:0];
      end else if (bus.address == SW_HI_A) begin
        rdata = {8'h00, deb[23:16]};
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // LED registers and sticky error flag; reset overrides any same-cycle write
  always_ff @(posedge clock) begin
    if (!reset) begin
      led_q <= '0;
      err_q <= 1'b0;
    end else begin
      led_q <= led_d;
      err_q <= err_d;
    end
  end

  assign bus.ioread_data = rdata;
  assign led_pins        = led_q;
  assign io_err          = err_q;

endmodule

// File: tb/tb_io_led_switch_responder.sv
// Purpose: self-checking bench for io_led_switch_responder with a short debounce window.
// Latency: checks one cycle after each drive, sampled 1ns after the rising edge.
// Backpressure: n/a.
module tb_io_led_switch_responder;
  import io_map_pkg::*;

  localparam int unsigned DEB = 8;

  logic        clock;
  logic        reset;
  logic [23:0] switch_pins;
  logic [23:0] led_pins;
  logic        io_err;

  io_led_switch_responder_if bus ();

  io_led_switch_responder #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (20)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .switch_pins(switch_pins),
    .led_pins   (led_pins),
    .io_err     (io_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        iow;
    logic        ior;
    logic        ledc;
    logic        swc;
    logic [23:0] led;
    logic [15:0] rd;
    logic        err;
  } vec_t;

  typedef struct {
    logic [23:0] led;
    logic [15:0] rd;
    logic        err;
  } exp_t;

  vec_t vecs[13];
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] wd,
                              input logic iow, input logic ior, input logic ledc,
                              input logic swc, input logic [23:0] led,
                              input logic [15:0] rd, input logic err);
    vec_t v;
    v.addr = a; v.wdata = wd; v.iow = iow; v.ior = ior; v.ledc = ledc; v.swc = swc;
    v.led = led; v.rd = rd; v.err = err;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, req);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic iow,
                       input logic ior, input logic ledc, input logic swc);
    @(negedge clock);
    bus.address    = a;
    bus.write_data = wd;
    bus.iowrite    = iow;
    bus.ioread     = ior;
    bus.LEDCtrl    = ledc;
    bus.SwitchCtrl = swc;
  endtask

  task automatic push(input logic [23:0] led, input logic [15:0] rd, input logic err);
    exp_t e;
    e.led = led; e.rd = rd; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic sample(input string nm);
    exp_t e;
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got led=%h rd=%h err=%b", nm, led_pins,
               bus.ioread_data, io_err);
    end else begin
      e = exp_q.pop_front();
      check({nm, " led"}, 32'(led_pins), 32'(e.led));
      check({nm, " rd"}, 32'(bus.ioread_data), 32'(e.rd));
      check({nm, " err"}, 32'(io_err), 32'(e.err));
    end
  endtask

  task automatic apply_vec(input int i);
    drive(vecs[i].addr, vecs[i].wdata, vecs[i].iow, vecs[i].ior, vecs[i].ledc, vecs[i].swc);
    push(vecs[i].led, vecs[i].rd, vecs[i].err);
    sample($sformatf("vec%0d", i));
  endtask

  initial begin
    // Table: expected state after the edge that consumes each vector
    vecs[0]  = mk(LED_BASE,     32'h0000_A5C3, 1, 0, 1, 0, 24'h00A5C3, 16'h0000, 0);
    vecs[1]  = mk(LED_BASE + 2, 32'h0000_007E, 1, 0, 1, 0, 24'h7EA5C3, 16'h0000, 0);
    vecs[2]  = mk(LED_BASE + 2, 32'hFFFF_FF55, 1, 0, 1, 0, 24'h55A5C3, 16'h0000, 0);
    vecs[3]  = mk(LED_BASE,     32'h0000_BEEF, 1, 0, 0, 0, 24'h55A5C3, 16'h0000, 0);
    vecs[4]  = mk(LED_BASE,     32'h0000_BEEF, 0, 0, 1, 0, 24'h55A5C3, 16'h0000, 0);
    vecs[5]  = mk(SW_BASE,      32'h0,         0, 1, 0, 1, 24'h55A5C3, 16'h0000, 0);
    vecs[6]  = mk(SW_BASE,      32'h0,         0, 1, 0, 1, 24'h55A5C3, 16'hABCD, 0);
    vecs[7]  = mk(SW_BASE + 2,  32'h0,         0, 1, 0, 1, 24'h55A5C3, 16'h0012, 0);
    vecs[8]  = mk(SW_BASE,      32'h0,         0, 1, 0, 0, 24'h55A5C3, 16'h0000, 0);
    vecs[9]  = mk(SW_BASE,      32'h0,         0, 0, 0, 1, 24'h55A5C3, 16'h0000, 0);
    vecs[10] = mk(LED_BASE + 4, 32'h0000_FFFF, 1, 0, 1, 0, 24'h55A5C3, 16'h0000, 1);
    vecs[11] = mk(LED_BASE,     32'h0000_1111, 1, 0, 1, 0, 24'h551111, 16'h0000, 1);
    vecs[12] = mk(SW_BASE + 2,  32'h0000_2222, 1, 1, 1, 1, 24'h551111, 16'h0012, 1);

    // Reset held two cycles with all switches high and a competing LED write
    reset       = 1'b0;
    switch_pins = 24'hFFFFFF;
    bus.address = LED_BASE; bus.write_data = 32'h1234; bus.iowrite = 1'b1;
    bus.ioread = 1'b0; bus.LEDCtrl = 1'b1; bus.SwitchCtrl = 1'b0;
    push(24'h0, 16'h0, 1'b0);
    sample("reset c1");
    push(24'h0, 16'h0, 1'b0);
    sample("reset c2");
    drive(SW_BASE, 32'h0, 0, 1, 0, 1);
    reset       = 1'b1;
    switch_pins = 24'h000000;
    push(24'h0, 16'h0, 1'b0);
    sample("post reset read");

    for (int i = 0; i <= 5; i++) apply_vec(i);

    // Bit0 bounces with a 3-cycle period, shorter than the window, then settles at 0
    drive(SW_BASE, 32'h0, 0, 1, 0, 1);
    for (int c = 0; c < 40; c++) begin
      if (c % 3 == 0) switch_pins[0] = ~switch_pins[0];
      push(24'h55A5C3, 16'h0000, 1'b0);
      sample($sformatf("bounce c%0d", c));
      @(negedge clock);
    end
    switch_pins = 24'h000000;
    for (int c = 0; c < 12; c++) begin
      push(24'h55A5C3, 16'h0000, 1'b0);
      sample($sformatf("settle c%0d", c));
    end

    // Clean change accepted exactly 2 + DEB edges after the pins move
    drive(SW_BASE, 32'h0, 0, 1, 0, 1);
    switch_pins = 24'h12ABCD;
    for (int k = 1; k <= 12; k++) begin
      push(24'h55A5C3, (k >= 2 + int'(DEB)) ? 16'hABCD : 16'h0000, 1'b0);
      sample($sformatf("accept k%0d", k));
    end

    for (int i = 6; i <= 12; i++) apply_vec(i);

    // Reset in the middle of a count, then full re-acceptance of the held value
    drive(SW_BASE, 32'h0, 0, 1, 0, 1);
    switch_pins = 24'h3CF00F;
    for (int k = 1; k <= 6; k++) begin
      push(24'h551111, 16'hABCD, 1'b1);
      sample($sformatf("midcount k%0d", k));
    end
    @(negedge clock);
    reset = 1'b0;
    push(24'h0, 16'h0000, 1'b0);
    sample("midcount reset");
    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      push(24'h0, (k >= 2 + int'(DEB)) ? 16'hF00F : 16'h0000, 1'b0);
      sample($sformatf("reaccept k%0d", k));
    end
    drive(SW_BASE + 2, 32'h0, 0, 1, 0, 1);
    push(24'h0, 16'h003C, 1'b0);
    sample("reaccept hi");

    // Unmapped read returns zero and sets the sticky flag
    drive(SW_BASE + 4, 32'h0, 0, 1, 0, 1);
    push(24'h0, 16'h0000, 1'b1);
    sample("unmapped read");
    drive(SW_BASE, 32'h0, 0, 1, 0, 1);
    push(24'h0, 16'hF00F, 1'b1);
    sample("sticky after read");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/io_led_switch_responder.md
Name: io_led_switch_responder

Overview:
- Peripheral-side responder for the CPU's memory-mapped IO bus.
- Decodes IO address, LED chip-select and switch chip-select from the CPU memory/IO steering logic.
- Latches written data into 24 LED output registers.
- Returns synchronized, debounced switch state as 16-bit IO read data. Sits between the CPU top and board pins.

Parameters:
- LED_BASE, 32'hFFFFFC60, LED low halfword address; LED_BASE+2 is the high byte.
- SW_BASE, 32'hFFFFFC70, switch low halfword address; SW_BASE+2 is the high byte.
- DEBOUNCE_CYCLES, 20'd1_000_000, cycles a switch vector must hold stable before acceptance.
- CNT_W, 20, debounce counter width.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-low reset.
- address  in  32  IO address from CPU.
- write_data  in  32  store data from CPU; only [15:0] used.
- iowrite  in  1  IO write strobe.
- ioread  in  1  IO read strobe.
- LEDCtrl  in  1  LED chip-select.
- SwitchCtrl  in  1  switch chip-select.
- switch_pins  in  24  raw asynchronous board switches.
- ioread_data  out  16  read data to CPU.
- led_pins  out  24  LED drive.
- io_err  out  1  sticky flag: IO access to an unmapped address.

Behaviour:
- Reset (reset==0 at a rising edge):
  - led_pins=0, io_err=0.
  - Synchronizer flops = 0, debounced switch register = 0, debounce counter = 0.
  - Reset wins over any simultaneous write.
- LED write:
  - Condition: iowrite & LEDCtrl.
  - address==LED_BASE → led_pins[15:0] <= write_data[15:0].
  - address==LED_BASE+2 → led_pins[23:16] <= write_data[7:0].
  - One-cycle latency: visible on led_pins the cycle after the edge.
  - Any other address → no LED change; io_err <= 1.
- Switch read (combinational, same cycle):
  - Condition: ioread & SwitchCtrl.
  - address==SW_BASE → ioread_data = deb[15:0].
  - address==SW_BASE+2 → ioread_data = {8'h00, deb[23:16]}.
  - Unmapped address → ioread_data = 0, and io_err <= 1 at the edge.
  - Not selected → ioread_data = 16'h0000.
- Synchronizer: switch_pins pass through 2 flops (s1, s2) before the debouncer; no combinational path from switch_pins to outputs.
- Debounce FSM, states STABLE / COUNTING:
  - STABLE: s2==deb → stay, cnt=0. s2!=deb → COUNTING, cnt<=1, cand<=s2.
  - COUNTING: s2!=cand → restart, cand<=s2, cnt<=1. s2==deb → STABLE, cnt<=0 (bounce back).
  - COUNTING: cnt==DEBOUNCE_CYCLES-1 with s2==cand → deb<=cand, STABLE.
  - Otherwise in COUNTING: cnt++.
  - Whole-vector debounce: any bit change restarts.
  - Counter saturates, never wraps.
- Acceptance latency from a stable pin change: 2 sync cycles + DEBOUNCE_CYCLES.
- Simultaneous iowrite & ioread: both handled independently; LED update and read data are unaffected by each other.
- Write while switches are counting: no interaction.
- io_err: sticky; cleared only by reset.
- Reset mid-count: FSM → STABLE, deb=0. A held switch value is re-accepted after the full latency.

Decomposition:
- Shared package io_map_pkg holds:
  - LED_BASE and SW_BASE constants.
  - Offsets LO=0, HI=2.
  - Debounce state enum {STABLE, COUNTING}.
- Sub-module switch_debounce: synchronizer + FSM + counter, parameterized width 24.
- Top-level module holds address decode, LED registers and io_err.

Test Plan:
- Reset check: reset=0 for 2 cycles with switch_pins=24'hFFFFFF → led_pins=0, ioread_data=0, io_err=0.
- LED writes:
  - LEDCtrl=1, iowrite=1, address=FFFFFC60, write_data=32'h0000A5C3 → led_pins[15:0]=A5C3 next cycle.
  - Then address=FFFFFC62, write_data=32'h0000007E → led_pins=24'h7EA5C3.
- Switch debounce (DEBOUNCE_CYCLES=8):
  - Set switch_pins=24'h12ABCD.
  - Read FFFFFC70 → 0 until cycle 10, then ABCD.
  - Read FFFFFC72 → 0012.
- Bounce rejection (DEBOUNCE_CYCLES=8): toggle bit0 every 3 cycles for 40 cycles, then hold 0 → deb stays at the old value; no acceptance occurs.
- Unmapped access:
  - iowrite, LEDCtrl, address=FFFFFC64 → led_pins unchanged, io_err=1.
  - io_err stays 1 after later valid accesses; clears only on reset.
- Reset during COUNTING mid-debounce → deb=0. The held value is re-accepted exactly 2+DEBOUNCE_CYCLES cycles after reset is released.
